// File: rtl/board_memory_if.sv
// Bus bundle for board_memory: renderer read port, game-logic read port,
// move request handshake and status outputs.
interface board_memory_if;
  logic [2:0] view_x;
  logic [2:0] view_y;
  logic [3:0] piece_read;
  logic [2:0] logic_x;
  logic [2:0] logic_y;
  logic [3:0] piece_logic;
  logic       move_req;
  logic [2:0] from_x;
  logic [2:0] from_y;
  logic [2:0] to_x;
  logic [2:0] to_y;
  logic       busy;
  logic       move_done;
  logic [3:0] captured_piece;
  logic       init_done;

  modport master (
    output view_x, view_y,
    input  piece_read,
    output logic_x, logic_y,
    input  piece_logic,
    output move_req,
    output from_x, from_y, to_x, to_y,
    input  busy, move_done,
    input  captured_piece, init_done
  );

  modport slave (
    input  view_x, view_y,
    output piece_read,
    input  logic_x, logic_y,
    output piece_logic,
    input  move_req,
    input  from_x, from_y, to_x, to_y,
    output busy, move_done,
    output captured_piece, init_done
  );
endinterface

// File: rtl/board_memory.sv
// 8x8 game board store: self-loading start layout, registered renderer
// port, combinational logic port and a read-write-clear move sequencer.
module board_memory (
  input  logic               clk,
  input  logic               reset,
  board_memory_if.slave      bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WRITE,
    S_CLEAR,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] src_q, src_d;
  logic [5:0] dst_q, dst_d;
  logic [3:0] spc_q, spc_d;
  logic [3:0] dpc_q, dpc_d;
  logic       init_done_q, init_done_d;
  logic       move_done_q, move_done_d;
  logic [3:0] cap_q, cap_d;
  logic [3:0] rd_q, rd_d;

  logic [3:0] board_q [64];

  logic       we;
  logic [5:0] waddr;
  logic [3:0] wdata;
  logic       same_sq;

  function automatic logic [3:0] layout(
    input logic [5:0] idx
  );
    logic [2:0] x;
    logic [2:0] y;
    logic [3:0] back;
    x = idx[2:0];
    y = idx[5:3];
    unique case (x)
      3'd0, 3'd7: back = 4'h4;
      3'd1, 3'd6: back = 4'h2;
      3'd2, 3'd5: back = 4'h3;
      3'd3:       back = 4'h5;
      default:    back = 4'h6;
    endcase
    unique case (y)
      3'd0:    layout = back;
      3'd1:    layout = 4'h1;
      3'd6:    layout = 4'h9;
      3'd7:    layout = {1'b1, back[2:0]};
      default: layout = 4'h0;
    endcase
  endfunction

  assign same_sq = (src_q == dst_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    dst_d       = dst_q;
    spc_d       = spc_q;
    dpc_d       = dpc_q;
    init_done_d = init_done_q;
    move_done_d = 1'b0;
    cap_d       = cap_q;
    we          = 1'b0;
    waddr       = cnt_q;
    wdata       = layout(cnt_q);
    unique case (state_q)
      S_INIT: begin
        we    = 1'b1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.move_req) begin
          src_d   = {bus.from_y, bus.from_x};
          dst_d   = {bus.to_y, bus.to_x};
          state_d = S_READ;
        end
      end
      S_READ: begin
        spc_d   = board_q[src_q];
        dpc_d   = board_q[dst_q];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        we      = !same_sq;
        waddr   = dst_q;
        wdata   = spc_q;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        we          = !same_sq;
        waddr       = src_q;
        wdata       = 4'h0;
        move_done_d = 1'b1;
        cap_d       = dpc_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_comb begin
    rd_d = 4'h0;
    if (init_done_q) begin
      rd_d = board_q[{bus.view_y, bus.view_x}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= 6'd0;
      src_q       <= 6'd0;
      dst_q       <= 6'd0;
      spc_q       <= 4'h0;
      dpc_q       <= 4'h0;
      init_done_q <= 1'b0;
      move_done_q <= 1'b0;
      cap_q       <= 4'h0;
      rd_q        <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      spc_q       <= spc_d;
      dpc_q       <= dpc_d;
      init_done_q <= init_done_d;
      move_done_q <= move_done_d;
      cap_q       <= cap_d;
      rd_q        <= rd_d;
    end
  end

  // Array contents are intentionally unreset; INIT rewrites every cell.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      board_q[waddr] <= wdata;
    end
  end

  assign bus.piece_read     = rd_q;
  assign bus.piece_logic    = board_q[{bus.logic_y, bus.logic_x}];
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.move_done      = move_done_q;
  assign bus.captured_piece = cap_q;
  assign bus.init_done      = init_done_q;

endmodule

// File: doc/board_memory.md
# board_memory

Storage block for the 8x8 game board. It holds one 4-bit piece code per square and serves the renderer's registered read port, answering `piece_read` for the `view_x`/`view_y` the renderer drives. A second combinational read port serves game logic. Moves from the game controller are executed as a sequenced read-write-clear operation. After every reset the block loads the standard starting layout itself.

## Interface
Parameters: none. Board is fixed at 8x8, 4-bit codes.

- `clk` in 1 — system clock.
- `reset` in 1 — synchronous, active-high; one clock, all state on `clk` rising edge.
- `view_x`, `view_y` in 3 each — renderer read address.
- `piece_read` out 4 — registered piece at (`view_x`,`view_y`).
- `logic_x`, `logic_y` in 3 each — game-logic read address.
- `piece_logic` out 4 — combinational piece at (`logic_x`,`logic_y`).
- `move_req` in 1 — single-cycle move request.
- `from_x`, `from_y`, `to_x`, `to_y` in 3 each — move operands; sampled only on acceptance.
- `busy` out 1 — high while not IDLE.
- `move_done` out 1 — one-cycle pulse at move completion.
- `captured_piece` out 4 — prior contents of the destination square for the last completed move.
- `init_done` out 1 — high once the starting layout is loaded.

## Operation
- Storage: 64 x 4-bit registers, index = {y,x}.
- Piece code: bit3 = colour (0 white, 1 black); bits[2:0] = type: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king. Type 7 is never written. Empty square = 4'h0 (4'h8 is never written).
- Starting layout:
  - y=0: 4,2,3,5,6,3,2,4 for x=0..7.
  - y=1: all 4'h1.
  - y=2..5: all 4'h0.
  - y=6: all 4'h9.
  - y=7: C,A,B,D,E,B,A,C (hex).
- FSM states: INIT, IDLE, READ, WRITE, CLEAR, DONE.
  - INIT: a 6-bit counter writes one layout cell per cycle, in index order 0..63. After cell 63 it goes to IDLE and sets `init_done`.
  - IDLE: `move_req`=1 latches the operands and goes to READ. `move_req` in any other state, including INIT, is ignored and not queued.
  - READ: latch src piece and dst piece into internal registers.
  - WRITE: dst <= latched src piece.
  - CLEAR: src <= 4'h0.
  - DONE: `move_done`=1, `captured_piece` <= latched dst piece, then go to IDLE.
- from==to: READ and DONE run normally, WRITE and CLEAR do not modify the array, and `captured_piece` is set to that square's code. The net effect is no change to the board.
- Empty source: the move still executes. The destination becomes 0 (the capture is still reported).
- No legality checking; that belongs to game logic.

## Timing
- Reset values:
  - state INIT, counter 0.
  - `init_done`=0, `busy`=1, `move_done`=0, `captured_piece`=0, `piece_read`=0.
  - Array contents are undefined until rewritten by INIT.
- Reset deasserted before cycle 1. Cycle k (1..64) writes cell k-1. `init_done`=1 and `busy`=0 from cycle 65.
- `piece_read` is forced to 0 while `init_done`=0.
- `piece_read`: 1-cycle latency, addresses sampled at edge N with data valid after edge N. Read-first: a same-cycle write to the addressed square returns the old value, and the new value appears the next cycle.
- `piece_logic`: combinational from current array contents.
- Move accepted at edge T (IDLE, `move_req`=1):
  - READ at T+1, WRITE at T+2 (dst updated after that edge), CLEAR at T+3 (src updated).
  - DONE at T+4: `move_done`=1 for exactly that cycle, `busy`=1.
  - IDLE at T+5: `busy`=0, new request accepted.
- Reset asserted mid-move or mid-INIT: abort immediately to INIT at counter 0. No `move_done` pulse. Partial move effects are overwritten by the layout load.

## Test plan
- Reset 1 cycle, release: `init_done` rises exactly at cycle 65. Reading all 64 squares via `piece_logic` matches the layout, e.g. (4,0)=6, (3,7)=D, (0,6)=9, (5,3)=0.
- After init, move (4,1)->(4,3):
  - `busy` high for 4 cycles.
  - `move_done` pulses at T+4, `captured_piece`=0.
  - (4,3)=1 and (4,1)=0.
- Capture: move (0,0)->(0,7) gives `captured_piece`=C, (0,7)=4, (0,0)=0. A second `move_req` pulsed at T+2 is ignored: board unchanged beyond the first move, exactly one `move_done` pulse.
- from==to at (3,0): `move_done` pulses, `captured_piece`=5, board identical before and after.
- Renderer port:
  - Sweep `view_x`/`view_y` every cycle; each `piece_read` equals the code of the address from the previous cycle.
  - With `view_*`=(4,3) held during a move into (4,3), `piece_read` shows the old value on the edge of the WRITE cycle and the new value one cycle later.
- Reset asserted at T+2 of a move: `busy` stays 1, `move_done` never pulses, and the board equals the starting layout at cycle 65 after release.
